// File: rtl/spi_master_slave.sv
// SPI mode-0 master and slave wired back-to-back in one clock domain.
// The master drives sclk/mosi/cs; the slave answers on miso and reports the word it received.
module spi_master_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] master_data_in,
    input  logic [DATA_WIDTH-1:0] slave_data_in,
    output logic [DATA_WIDTH-1:0] master_data_out,
    output logic [DATA_WIDTH-1:0] slave_data_out,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  miso,
    output logic                  cs,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF_W    = $clog2(2 * DATA_WIDTH);
    localparam int unsigned CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam int unsigned HALF_LAST = 2 * DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      div_cnt, div_cnt_next;
    logic [HALF_W-1:0]     half_cnt, half_cnt_next;
    logic                  armed, armed_next;
    logic                  cs_next, sclk_next, busy_next, done_next;
    logic                  load_tx, shift_tx, capture;
    logic [DATA_WIDTH-1:0] m_tx, m_rx;

    logic                  cs_q, sclk_q;
    logic                  cs_fall, cs_rise, s_rise, s_fall;
    logic [DATA_WIDTH-1:0] s_tx, s_rx;
    logic [CNT_W-1:0]      rx_cnt;

    logic                  div_end;

    assign div_end = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Master sequencing: LEAD holds sclk low, SHIFT toggles it, TRAIL closes the frame.
    always_comb begin
        state_next    = state;
        div_cnt_next  = div_cnt;
        half_cnt_next = half_cnt;
        armed_next    = armed;
        cs_next       = cs;
        sclk_next     = sclk;
        busy_next     = busy;
        done_next     = 1'b0;
        load_tx       = 1'b0;
        shift_tx      = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (!start) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    load_tx       = 1'b1;
                    cs_next       = 1'b0;
                    busy_next     = 1'b1;
                    armed_next    = 1'b0;
                    div_cnt_next  = '0;
                    half_cnt_next = '0;
                    state_next    = LEAD;
                end
            end
            LEAD: begin
                if (div_end) begin
                    div_cnt_next = '0;
                    sclk_next    = 1'b1;
                    state_next   = SHIFT;
                end else begin
                    div_cnt_next = DIV_W'(div_cnt + 1'b1);
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_cnt_next  = '0;
                    half_cnt_next = HALF_W'(half_cnt + 1'b1);
                    // The final half-period is the low phase after the last falling edge.
                    if (half_cnt == HALF_W'(HALF_LAST)) begin
                        state_next = TRAIL;
                    end else begin
                        sclk_next = ~sclk;
                        shift_tx  = sclk;
                    end
                end else begin
                    div_cnt_next = DIV_W'(div_cnt + 1'b1);
                end
            end
            TRAIL: begin
                cs_next    = 1'b1;
                capture    = 1'b1;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            div_cnt         <= '0;
            half_cnt        <= '0;
            armed           <= 1'b1;
            cs              <= 1'b1;
            sclk            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            m_tx            <= '0;
            m_rx            <= '0;
            master_data_out <= '0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            half_cnt <= half_cnt_next;
            armed    <= armed_next;
            cs       <= cs_next;
            sclk     <= sclk_next;
            busy     <= busy_next;
            done     <= done_next;
            if (load_tx) begin
                m_tx <= master_data_in;
            end else if (shift_tx) begin
                m_tx <= m_tx << 1;
            end
            // Master samples miso alongside the slave's registered view of the rising edge,
            // so the slave's load at cs fall is already visible on the first sample.
            if (s_rise) begin
                m_rx <= {m_rx[DATA_WIDTH-2:0], miso};
            end
            if (capture) begin
                master_data_out <= m_rx;
            end
        end
    end

    assign cs_fall = cs_q & ~cs;
    assign cs_rise = ~cs_q & cs;
    assign s_rise  = ~sclk_q & sclk & ~cs;
    assign s_fall  = sclk_q & ~sclk & ~cs;

    // Slave: edge detection on registered copies of cs and sclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q           <= 1'b1;
            sclk_q         <= 1'b0;
            s_tx           <= '0;
            s_rx           <= '0;
            rx_cnt         <= '0;
            slave_data_out <= '0;
        end else begin
            cs_q   <= cs;
            sclk_q <= sclk;
            if (cs_fall) begin
                rx_cnt <= '0;
                s_tx   <= slave_data_in;
            end else begin
                if (s_rise) begin
                    s_rx   <= {s_rx[DATA_WIDTH-2:0], mosi};
                    rx_cnt <= CNT_W'(rx_cnt + 1'b1);
                end
                if (s_fall) begin
                    s_tx <= s_tx << 1;
                end
            end
            if (cs_rise && rx_cnt == CNT_W'(DATA_WIDTH)) begin
                slave_data_out <= s_rx;
            end
        end
    end

    assign mosi = ~cs & m_tx[DATA_WIDTH-1];
    assign miso = ~cs & s_tx[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave with a bit/word scoreboard.
// Runs a CLK_DIV=1 instance for most scenarios and a CLK_DIV=3 instance for timing.
module tb_spi_master_slave;

    logic       clk, rst, start, start3;
    logic [7:0] mdi, sdi, mdo, sdo, mdi3, sdi3, mdo3, sdo3;
    logic       sclk, mosi, miso, cs, busy, done;
    logic       sclk3, mosi3, miso3, cs3, busy3, done3;

    int tests = 0;
    int fails = 0;

    logic       exp_mosi[$];
    logic       exp_miso[$];
    logic [7:0] exp_mdo[$];

    int   rises = 0, cs_low = 0, done_cnt = 0;
    logic prev_sclk = 1'b0;
    int   rises3 = 0, run3 = 0;
    logic prev_sclk3 = 1'b0, prev_cs3 = 1'b1;

    spi_master_slave #(.DATA_WIDTH(8), .CLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .master_data_in(mdi), .slave_data_in(sdi),
        .master_data_out(mdo), .slave_data_out(sdo),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs), .busy(busy), .done(done)
    );

    spi_master_slave #(.DATA_WIDTH(8), .CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .master_data_in(mdi3), .slave_data_in(sdi3),
        .master_data_out(mdo3), .slave_data_out(sdo3),
        .sclk(sclk3), .mosi(mosi3), .miso(miso3), .cs(cs3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-level scoreboard on every observed sclk rise; word check on done.
    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            rises++;
            if (exp_mosi.size() > 0) begin
                check("mosi_bit", 32'(mosi), 32'(exp_mosi.pop_front()));
                check("miso_bit", 32'(miso), 32'(exp_miso.pop_front()));
            end
        end
        prev_sclk = sclk;
        if (!cs) cs_low++;
        if (done) begin
            done_cnt++;
            if (exp_mdo.size() > 0) check("master_data_out", 32'(mdo), 32'(exp_mdo.pop_front()));
        end
    end

    // Half-period length of the divided build, measured from cs fall.
    always @(negedge clk) begin
        if (prev_cs3 && !cs3) begin
            run3 = 1;
        end else if (sclk3 != prev_sclk3) begin
            check("half_period3", 32'(run3), 32'd3);
            if (sclk3) rises3++;
            run3 = 1;
        end else begin
            run3++;
        end
        prev_cs3   = cs3;
        prev_sclk3 = sclk3;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] m, input logic [7:0] s);
        mdi = m;
        sdi = s;
        for (int i = 7; i >= 0; i--) begin
            exp_mosi.push_back(m[i]);
            exp_miso.push_back(s[i]);
        end
        exp_mdo.push_back(s);
        cs_low = 0;
        rises  = 0;
        start  = 1'b1;
    endtask

    task automatic wait_done(input int drop_at, input int mid_at, output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == drop_at) start = 1'b0;
            if (n == mid_at) begin
                mdi = ~mdi;
                sdi = ~sdi;
            end
        end while (!done && n < 200);
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        mdi = '0; sdi = '0; mdi3 = '0; sdi3 = '0;
        tick(); tick();
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mdo", 32'(mdo), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd0);
        rst = 1'b0;
        tick();

        // Basic exchange with start held for 10 cycles.
        launch(8'hD5, 8'hAA);
        wait_done(10, 0, n);
        check("latency", 32'(n), 32'd19);
        check("sclk_rises", 32'(rises), 32'd8);
        check("cs_low_cycles", 32'(cs_low), 32'd18);
        check("cs_high_at_done", 32'(cs), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        tick(); tick();
        check("slave_data_out", 32'(sdo), 32'hD5);
        check("done_pulses", 32'(done_cnt), 32'd1);

        // Held start: one transfer only, then re-arm.
        launch(8'h5A, 8'h96);
        wait_done(0, 0, n);
        for (int i = n; i < 40; i++) tick();
        check("held_done_pulses", 32'(done_cnt), 32'd2);
        check("held_rises", 32'(rises), 32'd8);
        check("held_busy", 32'(busy), 32'd0);
        check("held_sdo", 32'(sdo), 32'h5A);
        start = 1'b0;
        tick();
        launch(8'h3C, 8'hC3);
        wait_done(3, 0, n);
        tick(); tick();
        check("rearm_sdo", 32'(sdo), 32'h3C);

        // Inputs changed mid-transfer are ignored.
        start = 1'b0;
        tick();
        launch(8'hE7, 8'h18);
        wait_done(3, 5, n);
        tick(); tick();
        check("latch_sdo", 32'(sdo), 32'hE7);

        // Reset after four sclk rises.
        start = 1'b0;
        tick();
        launch(8'hA5, 8'h5A);
        n = 0;
        do begin tick(); n++; end while (rises < 4 && n < 100);
        check("rises_before_reset", 32'(rises), 32'd4);
        d0 = done_cnt;
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        exp_mosi.delete();
        exp_miso.delete();
        exp_mdo.delete();
        check("midrst_cs", 32'(cs), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mdo", 32'(mdo), 32'd0);
        check("midrst_sdo", 32'(sdo), 32'd0);
        for (int i = 0; i < 25; i++) tick();
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        launch(8'h66, 8'h99);
        wait_done(3, 0, n);
        check("post_rst_latency", 32'(n), 32'd19);
        tick(); tick();
        check("post_rst_sdo", 32'(sdo), 32'h66);

        // Divided clock build.
        mdi3 = 8'h81;
        sdi3 = 8'h7E;
        rises3 = 0;
        start3 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 5) start3 = 1'b0;
        end while (!done3 && n < 300);
        check("div3_done_seen", 32'(done3), 32'd1);
        check("div3_latency", 32'(n), 32'd53);
        check("div3_mdo", 32'(mdo3), 32'h7E);
        check("div3_rises", 32'(rises3), 32'd8);
        tick(); tick();
        check("div3_sdo", 32'(sdo3), 32'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
